// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// All bit transitions are paced by the shared baud tick TX_tick.
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// ARMED  | frame latched, waiting for the first tick to start the start bit
// START  | start bit (0) on the line
// DATA   | data bits, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit (1); a tick here may accept the next frame back-to-back
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TX_tick,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_tx_next;
    logic                  w_busy_next;

    assign w_accept   = DATA_VALID &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && TX_tick));
    assign w_last_bit = (r_cnt == CW'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every transition except IDLE->ARMED waits for a tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ARMED;
            S_ARMED:  if (TX_tick) w_next = S_START;
            S_START:  if (TX_tick) w_next = S_DATA;
            S_DATA:   if (TX_tick && w_last_bit) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (TX_tick) w_next = S_STOP;
            S_STOP:   if (TX_tick) w_next = w_accept ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state so TX_OUT and BUSY come straight from flops.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_next != S_IDLE);
        case (w_next)
            S_START:  w_tx_next = 1'b0;
            // A tick in DATA shifts the register, so the upcoming bit is at index 1.
            S_DATA:   w_tx_next = ((r_state == S_DATA) && TX_tick) ? r_shift[1] : r_shift[0];
            S_PARITY: w_tx_next = r_par_bit;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Registered line and busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            TX_OUT <= w_tx_next;
            BUSY   <= w_busy_next;
        end
    end

    // Frame capture on accept, then shift one bit per tick during DATA.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_bit <= (^P_DATA) ^ PAR_TYP;
        end else if ((r_state == S_DATA) && TX_tick) begin
            r_shift   <= r_shift >> 1;
        end
    end

    // Bit counter: counts data bits, held at zero outside DATA.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (r_state != S_DATA) begin
            r_cnt <= '0;
        end else if (TX_tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
